mem_window_reader: RTL

- Reader side of the convolution input memory.
- The master writes x samples into the register-array memory. This block walks the full array output and streams sliding windows of TAPS consecutive samples to the MAC datapath.
- Output uses a valid/ready handshake.
- Sits between the input memory's parallel data_out bus and the convolution MAC/control unit.

---
 rtl/mem_window_reader_pkg.sv | 18 +
 rtl/mem_window_reader_if.sv | 15 +
 rtl/mem_window_reader_window_select.sv | 37 +++
 rtl/mem_window_reader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mem_window_reader_pkg.sv
// Shared types and default sizing for the convolution input-memory window reader.
package mem_window_reader_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_SIZE    = 64;
    localparam int DEF_LOGSIZE = 6;
    localparam int DEF_TAPS    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

    typedef logic signed [DEF_WIDTH-1:0] window_t [DEF_TAPS];

endpackage

// File: rtl/mem_window_reader_if.sv
// Window stream bus from the reader to the MAC datapath (valid/ready).
interface mem_window_reader_if #(
    parameter int WIDTH   = 16,
    parameter int LOGSIZE = 6,
    parameter int TAPS    = 4
);
    logic signed [WIDTH-1:0] m_window [TAPS];
    logic [LOGSIZE-1:0]      m_index;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last;

    modport master (output m_window, m_index, m_valid, m_last, input m_ready);
    modport slave  (input m_window, m_index, m_valid, m_last, output m_ready);
endinterface

// File: rtl/mem_window_reader_window_select.sv
// Combinational tap selector: picks TAPS consecutive words starting at base.
// With ZERO_PAD_EN defined, taps at or beyond len read as zero.
module window_select #(
    parameter int WIDTH   = 16,
    parameter int SIZE    = 64,
    parameter int LOGSIZE = 6,
    parameter int TAPS    = 4
) (
    input  logic signed [WIDTH-1:0] mem_in [SIZE],
    input  logic [LOGSIZE:0]        base,
`ifdef ZERO_PAD_EN
    input  logic [LOGSIZE:0]        len,
`endif
    output logic signed [WIDTH-1:0] win [TAPS]
);
    localparam logic [LOGSIZE+1:0] SIZE_W = (LOGSIZE+2)'(SIZE);

    logic [LOGSIZE+1:0] pos;

    // Per-tap address and mask; one spare bit keeps base+k from wrapping.
    always_comb begin
        pos = '0;
        for (int k = 0; k < TAPS; k++) begin
            pos    = {1'b0, base} + (LOGSIZE+2)'(k);
            win[k] = '0;
`ifdef ZERO_PAD_EN
            if (pos < SIZE_W && pos < {1'b0, len}) begin
                win[k] = mem_in[pos[LOGSIZE-1:0]];
            end
`else
            if (pos < SIZE_W) begin
                win[k] = mem_in[pos[LOGSIZE-1:0]];
            end
`endif
        end
    end
endmodule

// File: rtl/mem_window_reader.sv
// Streams sliding TAPS-wide windows of the input memory to the MAC datapath.
// Optional build macro: ZERO_PAD_EN (one window per word, zero-padded tail).
//
//  state | meaning
//  IDLE  | waiting for start; bad len gives a one-cycle err
//  LOAD  | registering the first window
//  RUN   | presenting windows; advances on each accepted non-final window
//  FIN   | one-cycle done, busy already low
module mem_window_reader
    import mem_window_reader_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SIZE    = DEF_SIZE,
    parameter int LOGSIZE = DEF_LOGSIZE,
    parameter int TAPS    = DEF_TAPS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] mem_in [SIZE],
    input  logic                    start,
    input  logic [LOGSIZE:0]        len,
    output logic                    busy,
    output logic                    err,
    output logic                    done,
    mem_window_reader_if.master     m_if
);
    localparam logic [LOGSIZE:0] SIZE_L = (LOGSIZE+1)'(SIZE);
    localparam logic [LOGSIZE:0] TAPS_L = (LOGSIZE+1)'(TAPS);
`ifdef ZERO_PAD_EN
    localparam logic [LOGSIZE:0] MIN_LEN = (LOGSIZE+1)'(1);
`else
    localparam logic [LOGSIZE:0] MIN_LEN = TAPS_L;
`endif

    state_e                  state_q, state_d;
    logic [LOGSIZE:0]        idx_q, idx_d;
    logic [LOGSIZE:0]        len_q, len_d;
    logic signed [WIDTH-1:0] win_q [TAPS];
    logic signed [WIDTH-1:0] win_d [TAPS];
    logic signed [WIDTH-1:0] sel_win [TAPS];
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic [LOGSIZE:0]        sel_base;
    logic [LOGSIZE:0]        last_idx;
    logic                    advance;

`ifdef ZERO_PAD_EN
    assign last_idx = len_q - (LOGSIZE+1)'(1);
`else
    assign last_idx = len_q - TAPS_L;
`endif

    // The selector looks one window ahead on an accepted non-final beat so the
    // next window lands on the same edge, giving one window per cycle.
    assign advance  = (state_q == RUN) && valid_q && m_if.m_ready && !last_q;
    assign sel_base = advance ? idx_q + (LOGSIZE+1)'(1) : idx_q;

    window_select #(
        .WIDTH(WIDTH), .SIZE(SIZE), .LOGSIZE(LOGSIZE), .TAPS(TAPS)
    ) u_sel (
        .mem_in (mem_in),
        .base   (sel_base),
`ifdef ZERO_PAD_EN
        .len    (len_q),
`endif
        .win    (sel_win)
    );

    // Next-state and datapath load decisions.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        win_d   = win_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len >= MIN_LEN && len <= SIZE_L) begin
                        len_d   = len;
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                win_d   = sel_win;
                valid_d = 1'b1;
                last_d  = (sel_base == last_idx);
                state_d = RUN;
            end
            RUN: begin
                if (valid_q && m_if.m_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        idx_d  = sel_base;
                        win_d  = sel_win;
                        last_d = (sel_base == last_idx);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any pass in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            win_q   <= win_d;
        end
    end

    assign m_if.m_window = win_q;
    assign m_if.m_index  = idx_q[LOGSIZE-1:0];
    assign m_if.m_valid  = valid_q;
    assign m_if.m_last   = last_q;
    assign busy          = (state_q == LOAD) || (state_q == RUN);
    assign done          = (state_q == FIN);
    assign err           = err_q;
endmodule
